// File: rtl/sand_readout.sv
// sand_readout -- settle-and-readout controller for one row of sand cells.
//
// A pass starts on start_i in IDLE. The row is watched until no cell reports
// a collapse for SETTLE_CYCLES consecutive cycles, while the number of
// collapse-active cycles is counted into aval_len_o. The settled stack values
// are then captured into a snapshot and streamed out one cell per transfer
// over a valid/ready handshake. A one-cycle done_o pulse ends the pass.
//
// Ports:
//   clk           clock, all state changes on the rising edge
//   rst_n         asynchronous active-low reset
//   start_i       request a pass (sampled only in IDLE)
//   stack_i       per-cell {collapse, stack[1:0]}, cell 0 at the LSB
//   busy_o        state is not IDLE
//   data_o        stack value of the offered cell
//   data_valid_o  data_o is valid
//   data_ready_i  consumer accepts data_o this cycle
//   last_o        offered cell is the last one in the row
//   aval_len_o    collapse-active cycle count of the most recent pass
//   done_o        one-cycle pulse at the end of a pass
//
// state  | meaning
// IDLE   | waiting for start_i
// SETTLE | counting collapse-free cycles, accumulating avalanche length
// SHIFT  | streaming the snapshot, one cell per handshake
// DONE   | single-cycle done_o pulse, then back to IDLE

module sand_readout #(
  parameter int N_CELLS       = 8,
  parameter int SETTLE_CYCLES = 2,
  parameter int AVAL_W        = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_i,
  input  logic [3*N_CELLS-1:0]   stack_i,
  output logic                   busy_o,
  output logic [1:0]             data_o,
  output logic                   data_valid_o,
  input  logic                   data_ready_i,
  output logic                   last_o,
  output logic [AVAL_W-1:0]      aval_len_o,
  output logic                   done_o
);

  localparam int IDX_W = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CELLS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SHIFT  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                       state;
  logic [CNT_W-1:0]             settle_cnt;
  logic [IDX_W-1:0]             idx;
  logic [N_CELLS-1:0][1:0]      snapshot;

  logic [N_CELLS-1:0][1:0]      stack_now;
  logic                         any_collapse;
  logic                         settle_done;
  logic [IDX_W-1:0]             idx_nxt;

  always_comb begin
    any_collapse = 1'b0;
    stack_now    = '0;
    for (int k = 0; k < N_CELLS; k++) begin
      stack_now[k] = stack_i[3*k +: 2];
      any_collapse = any_collapse | stack_i[3*k+2];
    end
  end

  // This collapse-free edge completes the required run of quiet cycles.
  assign settle_done = (int'(settle_cnt) + 1) >= SETTLE_CYCLES;
  assign idx_nxt     = idx + IDX_W'(1);
  assign busy_o      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      settle_cnt   <= '0;
      idx          <= '0;
      snapshot     <= '0;
      data_o       <= '0;
      data_valid_o <= 1'b0;
      last_o       <= 1'b0;
      aval_len_o   <= '0;
      done_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data_valid_o <= 1'b0;
          last_o       <= 1'b0;
          done_o       <= 1'b0;
          if (start_i) begin
            state      <= SETTLE;
            settle_cnt <= '0;
            aval_len_o <= '0;
          end
        end

        SETTLE: begin
          if (any_collapse) begin
            settle_cnt <= '0;
            if (aval_len_o != {AVAL_W{1'b1}})
              aval_len_o <= aval_len_o + AVAL_W'(1);
          end else if (settle_done) begin
            // Outputs are loaded on the capture edge so cell 0 is offered
            // in the very next cycle.
            snapshot     <= stack_now;
            idx          <= '0;
            data_o       <= stack_now[0];
            data_valid_o <= 1'b1;
            last_o       <= (N_CELLS == 1);
            state        <= SHIFT;
          end else begin
            settle_cnt <= settle_cnt + CNT_W'(1);
          end
        end

        SHIFT: begin
          if (data_ready_i) begin
            if (last_o) begin
              state        <= DONE;
              data_o       <= '0;
              data_valid_o <= 1'b0;
              last_o       <= 1'b0;
              done_o       <= 1'b1;
            end else begin
              idx    <= idx_nxt;
              data_o <= snapshot[idx_nxt];
              last_o <= (idx_nxt == LAST_IDX);
            end
          end
        end

        DONE: begin
          done_o <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          state        <= IDLE;
          data_o       <= '0;
          data_valid_o <= 1'b0;
          last_o       <= 1'b0;
          done_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sand_readout.md
SAND_READOUT -- requirements
Module: sand_readout

Interface
REQ-001 Parameter N_CELLS, default 8: number of sand cells in the scanned row; minimum 1.
REQ-002 Parameter SETTLE_CYCLES, default 2: consecutive collapse-free cycles that define a settled row; minimum 1.
REQ-003 Parameter AVAL_W, default 8: width of the avalanche-length counter.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  request one settle-and-readout pass; sampled only in IDLE.
REQ-007 stack_i  input  3*N_CELLS  packed per-cell status; cell k occupies bits [3k+2:3k] as {collapse, stack[1:0]}; cell 0 at LSB.
REQ-008 busy_o  output  1  high whenever state is not IDLE.
REQ-009 data_o  output  2  stack value of the cell currently offered.
REQ-010 data_valid_o  output  1  data_o is valid.
REQ-011 data_ready_i  input  1  consumer accepts data_o this cycle.
REQ-012 last_o  output  1  the cell offered is cell N_CELLS-1.
REQ-013 aval_len_o  output  AVAL_W  collapse-active cycle count of the most recent pass.
REQ-014 done_o  output  1  one-cycle pulse at the end of a pass.

Function
REQ-015 States: IDLE, SETTLE, SHIFT, DONE; any other encoding SHALL return to IDLE.
REQ-016 any_collapse is the OR of the collapse bits of all N_CELLS cells.
REQ-017 IDLE: start_i=1 at an edge -> SETTLE; settle_cnt cleared; aval_len_o cleared.
REQ-018 SETTLE, any_collapse=1: settle_cnt <= 0; aval_len_o <= aval_len_o+1, saturating at 2^AVAL_W-1.
REQ-019 SETTLE, any_collapse=0, settle_cnt+1 < SETTLE_CYCLES: settle_cnt <= settle_cnt+1.
REQ-020 SETTLE, any_collapse=0, settle_cnt+1 = SETTLE_CYCLES: capture stack[1:0] of every cell into a snapshot register on that edge; idx <= 0; -> SHIFT.
REQ-021 No timeout: a row that never settles keeps the block in SETTLE until reset.
REQ-022 SHIFT: data_valid_o=1; data_o = snapshot[idx]; last_o = (idx == N_CELLS-1); outputs are registered or derived from registers only.
REQ-023 Handshake: transfer occurs when data_valid_o and data_ready_i are both 1 at an edge; data_o, last_o and idx SHALL stay stable while data_ready_i=0.
REQ-024 Transfer with last_o=0: idx <= idx+1. Transfer with last_o=1: -> DONE.
REQ-025 DONE lasts exactly one cycle: done_o=1, data_valid_o=0; then -> IDLE.
REQ-026 In IDLE and SETTLE, data_valid_o, last_o and done_o are 0.
REQ-027 start_i is ignored in SETTLE, SHIFT and DONE; stack_i is ignored outside SETTLE, so later collapses do not alter the snapshot.
REQ-028 aval_len_o holds its value from the end of SETTLE until the next accepted start_i.
REQ-029 Quiet row: the first data_valid_o is high in the cycle after the SETTLE_CYCLES-th edge following the start edge.

Reset
REQ-030 When rst_n=0, the block SHALL immediately go to IDLE, independent of clk.
REQ-031 When rst_n=0, busy_o, data_o, data_valid_o, last_o, aval_len_o, done_o, settle_cnt, idx and the snapshot SHALL be 0.
REQ-032 Reset asserted mid-pass aborts the pass without a done_o pulse; the first start_i after release begins a fresh pass.

Verification (N_CELLS=4, SETTLE_CYCLES=2, AVAL_W=8 unless stated)
REQ-033 Quiet row, stacks (cell0..3) = 1,2,3,0; start at edge 0; data_ready_i=1 -> valid from the cycle after edge 2; data_o = 1,2,3,0 on consecutive cycles; last_o on the 4th; done_o 1 cycle later; aval_len_o=0.
REQ-034 Cell 2 collapse bit high for edges 1..5, low afterwards -> aval_len_o=5; first valid in the cycle after edge 7; snapshot equals stack_i at edge 7.
REQ-035 Backpressure: data_ready_i=0 for 3 cycles while cell 1 is offered -> data_o=2 and last_o=0 held, valid held, no skip or duplicate.
REQ-036 AVAL_W=3, collapse high for 10 SETTLE edges -> aval_len_o saturates at 7.
REQ-037 rst_n pulled low during SHIFT (idx=2) -> all outputs 0 without a clock edge and no done_o; after release, a new start streams the full row from cell 0.
REQ-038 start_i pulsed during SETTLE and during SHIFT -> no restart; exactly one done_o pulse per accepted start.
